// File: rtl/gtxe2_chnl_pkg.sv
// Shared types for the channel CPLL power-up/reset sequencer.
package gtxe2_chnl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PWRDN     = 3'd1,
        RESET     = 3'd2,
        WAIT_LOCK = 3'd3,
        SETTLE    = 3'd4,
        READY     = 3'd5,
        FAIL      = 3'd6
    } cpll_state_e;

endpackage

// File: rtl/gtxe2_sync2.sv
// Two-flop synchronizer for single-bit level signals entering the clk domain.
module gtxe2_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gtxe2_chnl_cpll_seq.sv
// CPLL power-down / reset / lock sequencer with lock timeout, bounded retries
// and a registered "CPLL ready" qualifier for PCS reset release.
module gtxe2_chnl_cpll_seq
    import gtxe2_chnl_pkg::*;
#(
    parameter int unsigned PD_CYCLES     = 16,
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned SETTLE_CYCLES = 32,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       cpll_lock,
    input  logic       cpll_refclk_lost,
    output logic       cpll_pd,
    output logic       cpll_reset,
    output logic       cpll_locken,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] PD_LD  = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       MAX_R  = 3'(MAX_RETRIES);

    cpll_state_e      st, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       retry_nxt;
    logic             lock_s, lost_s, start_q, start_rise, bump;
    logic             pd_nxt, rst_nxt, locken_nxt;

    gtxe2_sync2 u_sync_lock (.clk(clk), .rst_n(rst_n), .d(cpll_lock),        .q(lock_s));
    gtxe2_sync2 u_sync_lost (.clk(clk), .rst_n(rst_n), .d(cpll_refclk_lost), .q(lost_s));

    assign start_rise = start & ~start_q;
    assign state      = st;

    always_comb begin
        nxt       = st;
        cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
        retry_nxt = retry_cnt;
        bump      = 1'b0;
        if (start_rise) begin
            nxt       = PWRDN;
            cnt_nxt   = PD_LD;
            retry_nxt = '0;
        end else begin
            unique case (st)
                PWRDN: if (cnt == '0) begin
                    nxt     = RESET;
                    cnt_nxt = RST_LD;
                end
                RESET: begin
                    if (lost_s) bump = 1'b1;
                    else if (cnt == '0) begin
                        nxt     = WAIT_LOCK;
                        cnt_nxt = TO_LD;
                    end
                end
                WAIT_LOCK: begin
                    if (lost_s) bump = 1'b1;
                    else if (lock_s) begin
                        nxt     = SETTLE;
                        cnt_nxt = ST_LD;
                    end else if (cnt == '0) bump = 1'b1;
                end
                SETTLE: begin
                    // a dropout restarts the lock wait without costing a retry
                    if (lost_s) bump = 1'b1;
                    else if (!lock_s) begin
                        nxt     = WAIT_LOCK;
                        cnt_nxt = TO_LD;
                    end else if (cnt == '0) begin
                        nxt     = READY;
                        cnt_nxt = '0;
                    end
                end
                READY: if (lost_s || !lock_s) begin
                    nxt       = PWRDN;
                    cnt_nxt   = PD_LD;
                    retry_nxt = '0;
                end
                default: ;
            endcase
        end
        if (bump) begin
            if (retry_cnt < MAX_R) begin
                nxt       = PWRDN;
                cnt_nxt   = PD_LD;
                retry_nxt = retry_cnt + 3'd1;
            end else begin
                nxt     = FAIL;
                cnt_nxt = '0;
            end
        end
        // outputs are decoded from the next state so they register with it
        pd_nxt     = !(nxt inside {RESET, WAIT_LOCK, SETTLE, READY});
        rst_nxt    = (nxt == RESET);
        locken_nxt = (nxt inside {WAIT_LOCK, SETTLE, READY});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= IDLE;
            cnt         <= '0;
            retry_cnt   <= '0;
            // a start level held through reset is not treated as a new request
            start_q     <= 1'b1;
            cpll_pd     <= 1'b1;
            cpll_reset  <= 1'b0;
            cpll_locken <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            st          <= nxt;
            cnt         <= cnt_nxt;
            retry_cnt   <= retry_nxt;
            start_q     <= start;
            cpll_pd     <= pd_nxt;
            cpll_reset  <= rst_nxt;
            cpll_locken <= locken_nxt;
            ready       <= (nxt == READY);
            fail        <= (nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_gtxe2_chnl_cpll_seq.sv
// Directed bench for the CPLL sequencer: nominal lock, latency, loss, glitch,
// timeout/fail, priority and async reset.
module tb_gtxe2_chnl_cpll_seq;

    localparam int PD = 4;
    localparam int RST = 3;
    localparam int LT = 64;
    localparam int SC = 12;
    localparam int MR = 3;

    logic       clk, rst_n, start, cpll_lock, cpll_refclk_lost;
    logic       cpll_pd, cpll_reset, cpll_locken, ready, fail;
    logic [2:0] retry_cnt, state;
    int         checks = 0;
    int         errors = 0;

    gtxe2_chnl_cpll_seq #(
        .PD_CYCLES(PD), .RST_CYCLES(RST), .LOCK_TIMEOUT(LT),
        .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cpll_lock(cpll_lock),
        .cpll_refclk_lost(cpll_refclk_lost), .cpll_pd(cpll_pd),
        .cpll_reset(cpll_reset), .cpll_locken(cpll_locken), .ready(ready),
        .fail(fail), .retry_cnt(retry_cnt), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget && state !== s; i++) tick(1);
        chk("wait_state", {29'd0, state}, {29'd0, s});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cpll_lock = 1'b0; cpll_refclk_lost = 1'b0;
        tick(3);
        chk("rst_pd", cpll_pd, 1);
        chk("rst_reset", cpll_reset, 0);
        chk("rst_locken", cpll_locken, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fail", fail, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_state", state, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_hold", state, 0);

        // nominal: lock arrives 50 cycles into WAIT_LOCK
        start = 1'b1;
        tick(1);
        chk("nom_pwrdn", state, 1);
        chk("nom_pd", cpll_pd, 1);
        tick(PD);
        chk("nom_reset_state", state, 2);
        chk("nom_reset_out", cpll_reset, 1);
        chk("nom_reset_pd", cpll_pd, 0);
        tick(RST);
        chk("nom_wait_state", state, 3);
        chk("nom_wait_reset", cpll_reset, 0);
        chk("nom_wait_locken", cpll_locken, 1);
        tick(49);
        cpll_lock = 1'b1;
        tick(SC + 2);
        chk("nom_not_ready", ready, 0);
        chk("nom_settle", state, 4);
        tick(1);
        chk("nom_ready", ready, 1);
        chk("nom_ready_state", state, 5);
        chk("nom_retry", retry_cnt, 0);

        // minimum latency re-sequence with lock already high
        start = 1'b0; tick(1); start = 1'b1;
        tick(1);
        chk("min_drop", ready, 0);
        chk("min_pwrdn", state, 1);
        tick(PD + RST + SC);
        chk("min_early", ready, 0);
        tick(1);
        chk("min_ready", ready, 1);

        // refclk lost pulse of 4 cycles while READY
        cpll_refclk_lost = 1'b1;
        tick(2);
        chk("lost_ready_hold", ready, 1);
        tick(1);
        chk("lost_ready_fall", ready, 0);
        chk("lost_pwrdn", state, 1);
        chk("lost_pd", cpll_pd, 1);
        tick(1);
        cpll_refclk_lost = 1'b0;
        tick(PD - 2);
        chk("lost_pd_last", cpll_pd, 1);
        tick(1);
        chk("lost_pd_done", cpll_pd, 0);
        wait_state(3'd5, 200);
        chk("lost_retry", retry_cnt, 0);

        // 3-cycle lock glitch three cycles into SETTLE
        start = 1'b0; tick(1); start = 1'b1;
        tick(5 + PD + RST);
        chk("gl_settle", state, 4);
        cpll_lock = 1'b0;
        tick(3);
        chk("gl_wait", state, 3);
        chk("gl_retry", retry_cnt, 0);
        cpll_lock = 1'b1;
        tick(SC + 2);
        chk("gl_not_ready", ready, 0);
        chk("gl_settle2", state, 4);
        tick(1);
        chk("gl_ready", ready, 1);

        // lock lost for good: timeouts then FAIL
        cpll_lock = 1'b0;
        wait_state(3'd3, 100);
        for (int r = 1; r <= MR; r++) begin
            tick(LT - 1);
            chk("to_wait_hold", state, 3);
            tick(1);
            chk("to_retry_state", state, 1);
            chk("to_retry_cnt", retry_cnt, r);
            wait_state(3'd3, 100);
        end
        tick(LT);
        chk("fail_state", state, 6);
        chk("fail_flag", fail, 1);
        chk("fail_pd", cpll_pd, 1);
        chk("fail_locken", cpll_locken, 0);
        chk("fail_retry", retry_cnt, MR);
        tick(5);
        chk("fail_sticky", fail, 1);
        start = 1'b0; tick(1); start = 1'b1;
        tick(1);
        chk("fail_clear", fail, 0);
        chk("fail_restart", state, 1);
        chk("fail_retry_clr", retry_cnt, 0);

        // lost and lock rise together in WAIT_LOCK
        wait_state(3'd3, 100);
        tick(5);
        cpll_refclk_lost = 1'b1; cpll_lock = 1'b1;
        tick(1);
        cpll_refclk_lost = 1'b0;
        tick(2);
        chk("prio_state", state, 1);
        chk("prio_retry", retry_cnt, 1);

        // async reset in WAIT_LOCK with start held high
        cpll_lock = 1'b0;
        wait_state(3'd3, 100);
        tick(3);
        chk("ar_retry_before", retry_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_state", state, 0);
        chk("ar_pd", cpll_pd, 1);
        chk("ar_locken", cpll_locken, 0);
        chk("ar_retry", retry_cnt, 0);
        rst_n = 1'b1;
        tick(10);
        chk("ar_no_start", state, 0);
        start = 1'b0; tick(1); start = 1'b1;
        tick(1);
        chk("ar_new_start", state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
